ex_muldiv_unit: RTL

Iterative multiply/divide unit in the EX stage, alongside the ALU, upstream of the EX/MEM pipeline register. It executes MULT/MULTU/DIV/DIVU over 32 cycles into architectural HI/LO registers and stalls the front of the pipeline meanwhile. It handles MTHI/MTLO writes and supplies HI/LO to the EX result mux for MFHI/MFLO.

---
 rtl/ex_muldiv_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the divide datapath (ops DIV/DIVU).
module ex_muldiv_unit #(
    parameter int word = 32
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            EX_MD_start,
    input  logic [2:0]      EX_MD_op,
    input  logic [word-1:0] EX_MD_a,
    input  logic [word-1:0] EX_MD_b,
    input  logic            EX_MD_flush,
    output logic            MD_busy,
    output logic            MD_done,
    output logic [word-1:0] MD_result,
    output logic [word-1:0] HI,
    output logic [word-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*word-1:0] acc_q, acc_d, step;
    logic [word-1:0]   mc_q, mc_d, hi_q, hi_d, lo_q, lo_d;
    logic              neg_q, neg_d;
    logic              sgn_op, a_neg, b_neg, is_mul, accept, start_ok;
    logic [word-1:0]   mag_a, mag_b;
    logic [word:0]     mul_sum;
    logic [2*word-1:0] mul_nxt, prod;
`ifdef MULDIV_DIV_EN
    logic              div_q, div_d, negr_q, negr_d, dz_q, dz_d;
    logic [word-1:0]   ar_q, ar_d, quo, rem;
    logic              is_div;
    logic [word:0]     rsh, diff;
    logic [2*word-1:0] div_nxt;
`endif

    assign sgn_op   = ~EX_MD_op[0];
    assign a_neg    = sgn_op & EX_MD_a[word-1];
    assign b_neg    = sgn_op & EX_MD_b[word-1];
    assign mag_a    = a_neg ? -EX_MD_a : EX_MD_a;
    assign mag_b    = b_neg ? -EX_MD_b : EX_MD_b;
    assign is_mul   = (EX_MD_op[2:1] == 2'b00);
    assign start_ok = (state_q == S_IDLE) && EX_MD_start && !EX_MD_flush;

    // acc holds {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc_q[2*word-1:word]}
                   + (acc_q[0] ? {1'b0, mc_q} : {(word+1){1'b0}});
    assign mul_nxt = {mul_sum, acc_q[word-1:1]};
    assign prod    = neg_q ? -mul_nxt : mul_nxt;

`ifdef MULDIV_DIV_EN
    // acc holds {remainder, dividend bits shifting into quotient}
    assign is_div  = (EX_MD_op[2:1] == 2'b01);
    assign accept  = is_mul | is_div;
    assign rsh     = {acc_q[2*word-1:word], acc_q[word-1]};
    assign diff    = rsh - {1'b0, mc_q};
    assign div_nxt = diff[word] ? {rsh[word-1:0], acc_q[word-2:0], 1'b0}
                                : {diff[word-1:0], acc_q[word-2:0], 1'b1};
    assign quo     = div_nxt[word-1:0];
    assign rem     = div_nxt[2*word-1:word];
    assign step    = div_q ? div_nxt : mul_nxt;
`else
    assign accept  = is_mul;
    assign step    = mul_nxt;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        MD_busy = 1'b0;
        MD_done = 1'b0;
`ifdef MULDIV_DIV_EN
        div_d   = div_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        ar_d    = ar_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_ok && accept) begin
                    MD_busy = 1'b1;
                    state_d = S_RUN;
                    cnt_d   = 5'd0;
                    acc_d   = {{word{1'b0}}, mag_b};
                    mc_d    = mag_a;
                    neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                    div_d   = is_div;
                    negr_d  = a_neg;
                    dz_d    = (EX_MD_b == '0);
                    ar_d    = EX_MD_a;
                    if (is_div) begin
                        acc_d = {{word{1'b0}}, mag_a};
                        mc_d  = mag_b;
                    end
`endif
                end else if (start_ok && EX_MD_op == 3'b100) begin
                    hi_d = EX_MD_a;
                end else if (start_ok && EX_MD_op == 3'b101) begin
                    lo_d = EX_MD_a;
                end
            end
            S_RUN: begin
                MD_busy = 1'b1;
                if (EX_MD_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                        hi_d    = prod[2*word-1:word];
                        lo_d    = prod[word-1:0];
`ifdef MULDIV_DIV_EN
                        if (div_q && dz_q) begin
                            hi_d = ar_q;
                            lo_d = '1;
                        end else if (div_q) begin
                            hi_d = negr_q ? -rem : rem;
                            lo_d = neg_q ? -quo : quo;
                        end
`endif
                    end
                end
            end
            S_DONE: begin
                MD_done = !EX_MD_flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= '0;
            mc_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            ar_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            div_q   <= div_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            ar_q    <= ar_d;
`endif
        end
    end

    always_comb begin
        MD_result = '0;
        if (EX_MD_op == 3'b110) MD_result = hi_q;
        else if (EX_MD_op == 3'b111) MD_result = lo_q;
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule
